// File: rtl/operand_tf_pkg.sv
// Shared types and constants for the operand transform sequencer.
package operand_tf_pkg;

    // Default maximum multiply passes per operand block.
    localparam int unsigned OPERAND_TF_MAX_PASSES = 4;

    // Sequencer states: each pass runs an EVEN then an ODD step.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/operand_tf_seq_perf.sv
// Saturating performance counters for the operand transform sequencer.
// Present only when OPERAND_TF_SEQ_PERF_EN is defined.
module operand_tf_seq_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        perf_clr,
    input  logic        blk_done,
    input  logic        blk_stall,
    output logic [31:0] perf_blocks,
    output logic [31:0] perf_stall
);

    logic [31:0] perf_blocks_q, perf_blocks_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Clear wins over increment; both counters stick at all-ones.
    always_comb begin
        perf_blocks_d = perf_blocks_q;
        perf_stall_d  = perf_stall_q;
        if (perf_clr) begin
            perf_blocks_d = '0;
            perf_stall_d  = '0;
        end else begin
            if (blk_done && (perf_blocks_q != '1)) perf_blocks_d = perf_blocks_q + 32'd1;
            if (blk_stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_blocks_q <= perf_blocks_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_blocks = perf_blocks_q;
    assign perf_stall  = perf_stall_q;

endmodule

// File: rtl/operand_tf_seq.sv
// Operand transform sequencer: steps a lane through EVEN/ODD multiply
// passes per accepted block, then holds the result until out_ready.
// Optional performance counters enabled by OPERAND_TF_SEQ_PERF_EN.
module operand_tf_seq
    import operand_tf_pkg::*;
#(
    parameter int unsigned MAX_PASSES = OPERAND_TF_MAX_PASSES,
    parameter int unsigned PASS_W     = $clog2(MAX_PASSES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PASS_W-1:0] num_passes,
    input  logic              flush,
    output logic              load_input,
    output logic              iter_sel,
    output logic              feedback_sel,
    output logic              we_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [PASS_W-1:0] pass_idx
`ifdef OPERAND_TF_SEQ_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [31:0]       perf_blocks,
    output logic [31:0]       perf_stall
`endif
);

    seq_state_e        state_q, state_d;
    logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
    logic [PASS_W-1:0] eff_passes_q, eff_passes_d;
    logic [PASS_W-1:0] clamped_passes;

    // Map the requested pass count into the legal range 1..MAX_PASSES.
    always_comb begin
        clamped_passes = num_passes;
        if (num_passes == '0) begin
            clamped_passes = PASS_W'(1);
        end else if (num_passes > PASS_W'(MAX_PASSES)) begin
            clamped_passes = PASS_W'(MAX_PASSES);
        end
    end

    // Next-state and lane strobes; flush overrides every transition.
    always_comb begin
        state_d      = state_q;
        pass_idx_d   = pass_idx_q;
        eff_passes_d = eff_passes_q;
        iter_sel     = 1'b0;
        feedback_sel = 1'b0;
        we_result    = 1'b0;
        out_valid    = 1'b0;
        busy         = (state_q != IDLE);
        in_ready     = rst_n && (state_q == IDLE) && !flush;
        load_input   = in_ready && in_valid;

        unique case (state_q)
            IDLE: begin
                if (load_input) begin
                    state_d      = EVEN;
                    pass_idx_d   = '0;
                    eff_passes_d = clamped_passes;
                end
            end
            EVEN: begin
                we_result    = 1'b1;
                feedback_sel = (pass_idx_q != '0);
                state_d      = ODD;
            end
            ODD: begin
                iter_sel     = 1'b1;
                we_result    = 1'b1;
                feedback_sel = (pass_idx_q != '0);
                if (pass_idx_q == eff_passes_q - PASS_W'(1)) begin
                    state_d = DONE;
                end else begin
                    pass_idx_d = pass_idx_q + PASS_W'(1);
                    state_d    = EVEN;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d    = IDLE;
            pass_idx_d = '0;
        end
    end

    // State, pass counter and latched pass count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pass_idx_q   <= '0;
            eff_passes_q <= PASS_W'(1);
        end else begin
            state_q      <= state_d;
            pass_idx_q   <= pass_idx_d;
            eff_passes_q <= eff_passes_d;
        end
    end

    assign pass_idx = pass_idx_q;

`ifdef OPERAND_TF_SEQ_PERF_EN
    operand_tf_seq_perf u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .perf_clr    (perf_clr),
        .blk_done    (out_valid && out_ready),
        .blk_stall   (out_valid && !out_ready),
        .perf_blocks (perf_blocks),
        .perf_stall  (perf_stall)
    );
`endif

endmodule

// File: tb/tb_operand_tf_seq.sv
// Directed bench for operand_tf_seq (default parameters, MAX_PASSES=4).
module tb_operand_tf_seq;

    localparam int PASS_W = 3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [PASS_W-1:0] num_passes;
    logic              flush;
    logic              load_input;
    logic              iter_sel;
    logic              feedback_sel;
    logic              we_result;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [PASS_W-1:0] pass_idx;
`ifdef OPERAND_TF_SEQ_PERF_EN
    logic              perf_clr;
    logic [31:0]       perf_blocks;
    logic [31:0]       perf_stall;
`endif

    operand_tf_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .num_passes   (num_passes),
        .flush        (flush),
        .load_input   (load_input),
        .iter_sel     (iter_sel),
        .feedback_sel (feedback_sel),
        .we_result    (we_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .pass_idx     (pass_idx)
`ifdef OPERAND_TF_SEQ_PERF_EN
        ,
        .perf_clr     (perf_clr),
        .perf_blocks  (perf_blocks),
        .perf_stall   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PASS_W-1:0] np;
        int                eff;
        int                lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One full block with out_ready held high; strobes checked every cycle.
    task automatic run_block(input logic [PASS_W-1:0] np, input int eff, input int lat);
        int cyc;
        in_valid   = 1'b1;
        num_passes = np;
        out_ready  = 1'b1;
        settle();
        chk("accept_in_ready", in_ready, 1);
        chk("accept_load_input", load_input, 1);
        step();
        cyc        = 1;
        in_valid   = 1'b0;
        num_passes = ~np;
        for (int k = 0; k < 2 * eff; k++) begin
            settle();
            chk("run_iter_sel", iter_sel, k % 2);
            chk("run_pass_idx", pass_idx, k / 2);
            chk("run_feedback_sel", feedback_sel, ((k / 2) != 0) ? 1 : 0);
            chk("run_we_result", we_result, 1);
            chk("run_busy", busy, 1);
            chk("run_out_valid", out_valid, 0);
            chk("run_in_ready", in_ready, 0);
            chk("run_load_input", load_input, 0);
            step();
            cyc++;
        end
        for (int w = 0; w < 20 && !out_valid; w++) begin
            step();
            cyc++;
        end
        chk("done_out_valid", out_valid, 1);
        chk("latency", cyc, lat);
        chk("done_we_result", we_result, 0);
        chk("done_iter_sel", iter_sel, 0);
        chk("done_in_ready", in_ready, 0);
        step();
        chk("after_done_busy", busy, 0);
        chk("after_done_in_ready", in_ready, 1);
        chk("after_done_out_valid", out_valid, 0);
    endtask

    initial begin
        vecs[0] = '{np: 3'd1, eff: 1, lat: 3};
        vecs[1] = '{np: 3'd3, eff: 3, lat: 7};
        vecs[2] = '{np: 3'd0, eff: 1, lat: 3};
        vecs[3] = '{np: 3'd7, eff: 4, lat: 9};
        vecs[4] = '{np: 3'd4, eff: 4, lat: 9};
        vecs[5] = '{np: 3'd2, eff: 2, lat: 5};

        rst_n      = 1'b0;
        in_valid   = 1'b1;
        num_passes = 3'd3;
        out_ready  = 1'b1;
        flush      = 1'b0;
`ifdef OPERAND_TF_SEQ_PERF_EN
        perf_clr   = 1'b0;
`endif

        // Reset with in_valid asserted: nothing accepted, outputs idle.
        step();
        step();
        settle();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_load_input", load_input, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_we_result", we_result, 0);
        chk("rst_iter_sel", iter_sel, 0);
        chk("rst_feedback_sel", feedback_sel, 0);
        chk("rst_pass_idx", pass_idx, 0);
`ifdef OPERAND_TF_SEQ_PERF_EN
        chk("rst_perf_blocks", perf_blocks, 0);
        chk("rst_perf_stall", perf_stall, 0);
`endif
        rst_n    = 1'b1;
        in_valid = 1'b0;
        settle();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        step();

        // Table of pass counts including 0 and over-range.
        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].np, vecs[i].eff, vecs[i].lat);
        end

        // Backpressure: five DONE cycles with out_ready low.
        in_valid   = 1'b1;
        num_passes = 3'd1;
        out_ready  = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_we_result", we_result, 0);
            chk("bp_busy", busy, 1);
            step();
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_out_valid", out_valid, 1);
        step();
        chk("bp_after_busy", busy, 0);
        chk("bp_after_out_valid", out_valid, 0);
`ifdef OPERAND_TF_SEQ_PERF_EN
        chk("perf_blocks", perf_blocks, 7);
        chk("perf_stall", perf_stall, 5);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        chk("perf_clr_blocks", perf_blocks, 0);
        chk("perf_clr_stall", perf_stall, 0);
`endif

        // Flush in IDLE blocks the accept.
        flush    = 1'b1;
        in_valid = 1'b1;
        settle();
        chk("flush_idle_in_ready", in_ready, 0);
        chk("flush_idle_load_input", load_input, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        settle();
        chk("flush_idle_busy", busy, 0);

        // Flush during ODD of pass 1.
        in_valid   = 1'b1;
        num_passes = 3'd3;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        settle();
        chk("pre_flush_iter_sel", iter_sel, 1);
        chk("pre_flush_pass_idx", pass_idx, 1);
        chk("pre_flush_feedback_sel", feedback_sel, 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        settle();
        chk("flush_odd_in_ready", in_ready, 0);
        chk("flush_odd_load_input", load_input, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        settle();
        chk("flush_busy", busy, 0);
        chk("flush_pass_idx", pass_idx, 0);
        chk("flush_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            chk("flush_no_out_valid", out_valid, 0);
            step();
        end
        run_block(3'd2, 2, 5);

        // Reset in the middle of EVEN discards the block.
        in_valid   = 1'b1;
        num_passes = 3'd2;
        step();
        in_valid = 1'b0;
        settle();
        chk("mid_even_busy", busy, 1);
        chk("mid_even_we_result", we_result, 1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        settle();
        chk("mid_rst_load_input", load_input, 0);
        step();
        settle();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_we_result", we_result, 0);
        chk("mid_rst_iter_sel", iter_sel, 0);
        chk("mid_rst_feedback_sel", feedback_sel, 0);
        chk("mid_rst_pass_idx", pass_idx, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        step();
        chk("mid_rst_hold_busy", busy, 0);
        rst_n    = 1'b0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        settle();
        chk("mid_rst_release_in_ready", in_ready, 1);
        step();
        run_block(3'd1, 1, 3);
`ifdef OPERAND_TF_SEQ_PERF_EN
        chk("perf_after_rst_blocks", perf_blocks, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
